// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder controller.
//   state_t   : controller FSM state (IDLE, RUN, DONE), 2 bits
//   WIDTH_DEF : default operand width
//   cnt_w()   : bit-counter width for a given operand width
package serial_adder_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// fa_bit_cell: purely combinational one-bit full adder.
//   a, b, ci : addend bits and carry-in
//   s        : sum bit
//   co       : carry-out (majority of the three inputs)
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per cycle, LSB first,
// through a single full-adder cell with a registered carry.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request; accepted only when busy=0 (IDLE or DONE)
//   a, b, cin    : operands and carry-in, sampled on the accepting edge
//   busy         : high for the WIDTH cycles of RUN
//   done         : one-cycle pulse when sum/cout become valid
//   sum, cout    : result, held until the next result is delivered
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_sh_q, sum_sh_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             s, co, run, last, accept;

    fa_bit_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        run      = state_q == RUN;
        last     = run && cnt_q == CW'(WIDTH - 1);
        accept   = start && !run;
        state_d  = run ? (last ? DONE : RUN) : (start ? RUN : IDLE);
        a_d      = accept ? a : (run ? a_q >> 1 : a_q);
        b_d      = accept ? b : (run ? b_q >> 1 : b_q);
        carry_d  = accept ? cin : (run ? co : carry_q);
        sum_sh_d = accept ? '0 : (run ? {s, sum_sh_q[WIDTH-1:1]} : sum_sh_q);
        // counter holds on the final RUN cycle so it never wraps
        cnt_d    = accept ? '0 : ((run && !last) ? cnt_q + 1'b1 : cnt_q);
        sum_d    = last ? {s, sum_sh_q[WIDTH-1:1]} : sum_q;
        cout_d   = last ? co : cout_q;
    end

    always_comb begin
        busy = state_q == RUN;
        done = state_q == DONE;
        sum  = sum_q;
        cout = cout_q;
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st[2];
    logic [31:0] av[2];
    logic [31:0] bv[2];
    logic        ci[2];
    logic        bz[2];
    logic        dn[2];
    logic [7:0]  sum8;
    logic [4:0]  sum5;
    logic        cout8, cout5;
    logic [32:0] res_act[2];

    int checks = 0;
    int failures = 0;

    const int WV[2] = '{8, 5};

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(av[0][7:0]), .b(bv[0][7:0]), .cin(ci[0]),
        .busy(bz[0]), .done(dn[0]), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(st[1]), .a(av[1][4:0]), .b(bv[1][4:0]), .cin(ci[1]),
        .busy(bz[1]), .done(dn[1]), .sum(sum5), .cout(cout5)
    );

    assign res_act[0] = {24'b0, cout8, sum8};
    assign res_act[1] = {27'b0, cout5, sum5};

    task automatic chk(input string nm, input int i, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[w%0d] got=%0h exp=%0h at %0t", nm, WV[i], act, exp, $time);
        end
    endtask

    // Model: each accepted operation occupies cycles lo..hi (busy) and delivers
    // a+b+cin in cycle hi+1 (done); the delivered value is held afterwards.
    int          ec = 0;
    bit          ready = 0;
    bit          pend[2];
    int          lo[2], hi[2];
    logic [32:0] expr[2], held[2];

    always @(posedge clk) begin
        ec = ec + 1;
        if (rst) ready = 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pend[i] = 0;
                held[i] = '0;
            end else begin
                if (pend[i] && ec == hi[i] + 1) held[i] = expr[i];
                if (st[i] && !(pend[i] && ec - 1 >= lo[i] && ec - 1 <= hi[i])) begin
                    logic [32:0] m;
                    m = (33'd1 << WV[i]) - 33'd1;
                    pend[i] = 1;
                    lo[i] = ec;
                    hi[i] = ec + WV[i] - 1;
                    expr[i] = ({1'b0, av[i]} & m) + ({1'b0, bv[i]} & m) + 33'(ci[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ready) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 33'(bz[i]), 33'(pend[i] && ec >= lo[i] && ec <= hi[i]));
                chk("done", i, 33'(dn[i]), 33'(pend[i] && ec == hi[i] + 1));
                chk("result", i, res_act[i], held[i]);
            end
        end
    end

    task automatic op8(input logic [7:0] a_, input logic [7:0] b_, input logic c_,
                       input logic [7:0] es, input logic ec_, input bit inj);
        int n;
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'(a_); bv[0] = 32'(b_); ci[0] = c_;
        @(negedge clk);
        st[0] = 1'b0; av[0] = $urandom; bv[0] = $urandom; ci[0] = 1'($urandom);
        n = 1;
        while (!dn[0] && n < 30) begin
            @(negedge clk);
            n++;
            if (inj && n == 3) begin
                st[0] = 1'b1; av[0] = 32'h11; bv[0] = 32'h22; ci[0] = 1'b0;
            end else if (inj && n == 4) st[0] = 1'b0;
        end
        chk("latency", 0, 33'(n), 33'd9);
        chk("sum_lit", 0, 33'(sum8), 33'(es));
        chk("cout_lit", 0, 33'(cout8), 33'(ec_));
    endtask

    task automatic rand_ops(input int i, input int cnt);
        int t;
        for (int j = 0; j < cnt; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            t = 0;
            while (bz[i] && t < 40) begin
                st[i] = ($urandom_range(0, 3) == 0);
                av[i] = $urandom; bv[i] = $urandom; ci[i] = 1'($urandom);
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                failures++;
                $display("FAIL busy_timeout[w%0d] got=busy exp=idle", WV[i]);
            end
            st[i] = 1'b1; av[i] = $urandom; bv[i] = $urandom; ci[i] = 1'($urandom);
            @(negedge clk);
            st[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        for (int i = 0; i < 2; i++) begin
            st[i] = 1'b0; av[i] = '0; bv[i] = '0; ci[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 0, 33'(bz[0]), 33'd0);
        chk("rst_done", 0, 33'(dn[0]), 33'd0);
        chk("rst_res", 0, res_act[0], 33'd0);

        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
        op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1);

        // reset during the 4th RUN cycle discards the operation
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h01; bv[0] = 32'h02; ci[0] = 1'b0;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 0, 33'(bz[0]), 33'd0);
        chk("mid_rst_done", 0, 33'(dn[0]), 33'd0);
        chk("mid_rst_res", 0, res_act[0], 33'd0);
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_rst", 0, 33'(dn[0]), 33'd0);
        end
        op8(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0);

        // back-to-back with start held high
        @(negedge clk);
        st[0] = 1'b1; av[0] = 32'h12; bv[0] = 32'h34; ci[0] = 1'b0;
        m = 0;
        while (!dn[0] && m < 30) begin
            @(negedge clk);
            m++;
        end
        chk("b2b_first_sum", 0, res_act[0], 33'h046);
        av[0] = 32'h80; bv[0] = 32'h80;
        m = 0;
        while (m < 30) begin
            @(negedge clk);
            m++;
            st[0] = 1'b0;
            if (dn[0]) break;
            chk("b2b_hold", 0, res_act[0], 33'h046);
        end
        chk("b2b_gap", 0, 33'(m), 33'd9);
        chk("b2b_second", 0, res_act[0], 33'h100);

        fork
            rand_ops(0, 600);
            rand_ops(1, 600);
        join
        repeat (12) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
